mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port K&S data/program RAM between the processor core and an external
//  loader/debug port. Decides the owner each cycle, routes address/data/write-enable to
//  the RAM and returns read data with a valid strobe. Includes starvation protection and
//  a locked-burst mode for program loading.
//  Sits between the datapath memory interface, the loader port and the RAM macro.
// PARAMETERS
//  ADDR_W    5   RAM address width (32 words)
//  DATA_W    16  RAM data width
//  MAX_WAIT  4   consecutive denied ext cycles before ext is forced to win (>=1)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous reset, active-high
//  halt         in   1       core halted; ext wins every contention
//  core_req     in   1       core requests an access this cycle
//  core_we      in   1       1=write, 0=read
//  core_addr    in   ADDR_W  core address
//  core_wdata   in   DATA_W  core write data
//  core_gnt     out  1       core access performed this cycle
//  core_rvalid  out  1       core read data valid (cycle after read grant)
//  core_rdata   out  DATA_W  read data to core
//  ext_req      in   1       loader requests an access
//  ext_we       in   1       1=write, 0=read
//  ext_lock     in   1       keep ownership after this ext access
//  ext_addr     in   ADDR_W  loader address
//  ext_wdata    in   DATA_W  loader write data
//  ext_gnt      out  1       ext access performed this cycle
//  ext_rvalid   out  1       ext read data valid
//  ext_rdata    out  DATA_W  read data to loader
//  ram_addr     out  ADDR_W  RAM address
//  ram_we       out  1       RAM write enable
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, 1-cycle synchronous read
//  owner        out  2       00 none, 01 core, 10 ext (combinational, this cycle)
// BEHAVIOUR
//  - Grants are combinational from current requests plus registered state. Requester
//    holds req/addr/we/wdata until it sees gnt. An access completes in its grant cycle.
//  - Registered state: lock state {UNLOCKED, EXT_LOCKED}; wait_cnt (0..MAX_WAIT, saturating).
//  - Arbitration order in a cycle:
//    1. rst=1: no grant.
//    2. EXT_LOCKED: only ext may be granted. core_gnt=0 even if ext_req=0.
//    3. ext_req and (halt or wait_cnt==MAX_WAIT or !core_req): ext granted.
//    4. core_req: core granted.
//    5. Otherwise: no grant.
//  - At most one gnt per cycle.
//  - Lock: on posedge, state <= EXT_LOCKED if ext_gnt && ext_lock;
//    state <= UNLOCKED if ext_gnt && !ext_lock; otherwise unchanged.
//  - wait_cnt: cleared on ext_gnt or !ext_req; else +1 if ext_req && !ext_gnt, saturating.
//  - RAM mux: ram_* driven from the granted requester. With no grant, ram_we=0,
//    ram_addr=0 and ram_wdata=0.
//  - Read return: core_rvalid <= core_gnt & !core_we; ext_rvalid <= ext_gnt & !ext_we.
//    core_rdata and ext_rdata both wire to ram_rdata, so latency is 1 cycle.
//  - A write returns no rvalid. Back-to-back reads from alternating owners are legal:
//    each rvalid matches its own prior grant.
//  - Reset state: state=UNLOCKED, wait_cnt=0, both rvalid=0. All gnt=0, ram_we=0, owner=00.
//  - Reset mid-lock or mid-read: lock dropped, pending rvalid suppressed.
//    First cycle after rst deasserts arbitrates from UNLOCKED.
//  - halt does not break an active lock. It only biases contention.
// TESTING
//  1. rst=1 for 2 cycles with core_req=ext_req=1, we=1 -> core_gnt=ext_gnt=0, ram_we=0, rvalid=0.
//  2. RAM[5]=16'h1234; core read addr 5 -> core_gnt same cycle; next cycle core_rvalid=1,
//     core_rdata=16'h1234; ext_rvalid=0.
//  3. MAX_WAIT=4, core_req and ext_req held high -> core granted cycles 0-3, ext cycle 4,
//     core cycles 5-8, ext cycle 9.
//  4. halt=1, both requesting continuously -> ext_gnt=1 every cycle, core_gnt=0.
//  5. ext writes addr 0..7 with ext_lock=1 (0 on last), core_req high throughout ->
//     8 ext grants, core_gnt=0 throughout, core granted the cycle after the last ext write.
//  6. Lock held, rst pulsed 1 cycle while an ext read is granted -> no rvalid.
//     After reset a pending core_req is granted on the first cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port K&S RAM between the processor core and the loader/debug port.
// Grants are combinational; registered state covers the loader lock, the starvation counter and read-valid strobes.
module mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic {
    UNLOCKED,
    EXT_LOCKED
  } lock_state_t;

  lock_state_t       state;
  lock_state_t       state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              wait_full;
  logic              core_rvalid_q;
  logic              ext_rvalid_q;

  assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));

  // Priority: reset, active lock, ext when favoured (halt, starved or uncontended), then core.
  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (!rst) begin
      if (state == EXT_LOCKED) begin
        ext_gnt = ext_req;
      end else if (ext_req && (halt || wait_full || !core_req)) begin
        ext_gnt = 1'b1;
      end else if (core_req) begin
        core_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    owner     = 2'b00;
    if (ext_gnt) begin
      ram_addr  = ext_addr;
      ram_we    = ext_we;
      ram_wdata = ext_wdata;
      owner     = 2'b10;
    end else if (core_gnt) begin
      ram_addr  = core_addr;
      ram_we    = core_we;
      ram_wdata = core_wdata;
      owner     = 2'b01;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    if (ext_gnt) begin
      state_next = ext_lock ? EXT_LOCKED : UNLOCKED;
    end
    if (ext_gnt || !ext_req) begin
      wait_cnt_next = '0;
    end else if (!wait_full) begin
      wait_cnt_next = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= UNLOCKED;
      wait_cnt      <= '0;
      core_rvalid_q <= 1'b0;
      ext_rvalid_q  <= 1'b0;
    end else begin
      state         <= state_next;
      wait_cnt      <= wait_cnt_next;
      core_rvalid_q <= core_gnt & ~core_we;
      ext_rvalid_q  <= ext_gnt & ~ext_we;
    end
  end

  // A read strobe still registered when reset arrives must not reach the requester.
  assign core_rvalid = core_rvalid_q & ~rst;
  assign ext_rvalid  = ext_rvalid_q & ~rst;
  assign core_rdata  = ram_rdata;
  assign ext_rdata   = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              ext_req;
  logic              ext_we;
  logic              ext_lock;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        owner;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem     [32];
  logic [DATA_W-1:0] ref_mem [32];

  bit                m_locked;
  int                m_wait;
  bit                m_core_rv;
  bit                m_ext_rv;
  logic [DATA_W-1:0] m_core_rd;
  logic [DATA_W-1:0] m_ext_rd;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM macro stand-in.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = '0; ext_wdata = '0;
    halt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({core_gnt, ext_gnt, ram_we, owner} !== 5'b0) begin
        failures++;
        $display("[TB] FAIL reset_grant cycle %0d: got gnt=%b%b we=%b owner=%b expected all 0",
                 i, core_gnt, ext_gnt, ram_we, owner);
      end
      checks++;
      if ({core_rvalid, ext_rvalid} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_rvalid cycle %0d: got %b%b expected 00", i, core_rvalid, ext_rvalid);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_core_read();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 5'd5; ext_wdata = 16'h1234;
    #1;
    checks++;
    if (ext_gnt !== 1'b1 || ram_we !== 1'b1) begin
      failures++;
      $display("[TB] FAIL preload_write: got ext_gnt=%b ram_we=%b expected 1 1", ext_gnt, ram_we);
    end
    @(negedge clk);
    idle();
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'd5;
    #1;
    checks++;
    if (core_gnt !== 1'b1 || owner !== 2'b01 || ram_addr !== 5'd5) begin
      failures++;
      $display("[TB] FAIL core_read_grant: got gnt=%b owner=%b addr=%0d expected 1 01 5",
               core_gnt, owner, ram_addr);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (core_rvalid !== 1'b1 || core_rdata !== 16'h1234 || ext_rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL core_read_data: got rvalid=%b rdata=%h ext_rvalid=%b expected 1 1234 0",
               core_rvalid, core_rdata, ext_rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'd1;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 5'd2;
    for (int i = 0; i < 10; i++) begin
      bit exp_ext;
      exp_ext = (i == MAX_WAIT) || (i == 2 * MAX_WAIT + 1);
      #1;
      checks++;
      if (ext_gnt !== exp_ext || core_gnt !== !exp_ext) begin
        failures++;
        $display("[TB] FAIL starvation cycle %0d: got core=%b ext=%b expected core=%b ext=%b",
                 i, core_gnt, ext_gnt, !exp_ext, exp_ext);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_halt();
    halt = 1'b1;
    core_req = 1'b1; ext_req = 1'b1; ext_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ext_addr = ADDR_W'(i);
      #1;
      checks++;
      if (ext_gnt !== 1'b1 || core_gnt !== 1'b0 || owner !== 2'b10) begin
        failures++;
        $display("[TB] FAIL halt cycle %0d: got core=%b ext=%b owner=%b expected 0 1 10",
                 i, core_gnt, ext_gnt, owner);
      end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_locked_burst();
    logic [DATA_W-1:0] data [8];
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'd0;
    for (int i = 0; i < 8; i++) begin
      data[i]   = DATA_W'($urandom);
      halt      = (i == 0);
      ext_req   = 1'b1; ext_we = 1'b1; ext_lock = (i != 7);
      ext_addr  = ADDR_W'(i); ext_wdata = data[i];
      #1;
      checks++;
      if (ext_gnt !== 1'b1 || core_gnt !== 1'b0 || ram_addr !== ADDR_W'(i) || ram_wdata !== data[i]) begin
        failures++;
        $display("[TB] FAIL burst_write %0d: got ext=%b core=%b addr=%0d data=%h expected 1 0 %0d %h",
                 i, ext_gnt, core_gnt, ram_addr, ram_wdata, i, data[i]);
      end
      @(negedge clk);
    end
    halt = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    #1;
    checks++;
    if (core_gnt !== 1'b1 || ext_gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL burst_release: got core=%b ext=%b expected 1 0", core_gnt, ext_gnt);
    end
    @(negedge clk);
    core_req = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      ext_req = (i < 8); ext_we = 1'b0; ext_addr = ADDR_W'(i);
      #1;
      if (i == 0) begin
        checks++;
        if (core_rvalid !== 1'b1 || core_rdata !== data[0]) begin
          failures++;
          $display("[TB] FAIL burst_core_read: got rvalid=%b rdata=%h expected 1 %h",
                   core_rvalid, core_rdata, data[0]);
        end
      end else begin
        checks++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== data[i-1]) begin
          failures++;
          $display("[TB] FAIL burst_readback %0d: got rvalid=%b rdata=%h expected 1 %h",
                   i - 1, ext_rvalid, ext_rdata, data[i-1]);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_reset_mid_lock();
    ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = 5'd9; ext_wdata = 16'hBEEF;
    @(negedge clk);
    ext_we = 1'b0; ext_addr = 5'd3;
    core_req = 1'b1; core_we = 1'b1; core_addr = 5'd1; core_wdata = 16'h0011;
    #1;
    checks++;
    if (ext_gnt !== 1'b1 || core_gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL locked_read_grant: got ext=%b core=%b expected 1 0", ext_gnt, core_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ext_rvalid !== 1'b0 || ext_gnt !== 1'b0 || core_gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_pulse: got ext_rvalid=%b ext=%b core=%b expected 0 0 0",
               ext_rvalid, ext_gnt, core_gnt);
    end
    @(negedge clk);
    rst = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    #1;
    checks++;
    if (ext_rvalid !== 1'b0 || core_gnt !== 1'b1 || owner !== 2'b01) begin
      failures++;
      $display("[TB] FAIL after_reset: got ext_rvalid=%b core=%b owner=%b expected 0 1 01",
               ext_rvalid, core_gnt, owner);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  // Reference arbitration taken straight from the ownership rules.
  function automatic void model_grant(output bit cg, output bit eg);
    cg = 1'b0;
    eg = 1'b0;
    if (rst) return;
    if (m_locked) begin
      eg = ext_req;
    end else if (ext_req && (halt || m_wait >= MAX_WAIT || !core_req)) begin
      eg = 1'b1;
    end else if (core_req) begin
      cg = 1'b1;
    end
  endfunction

  task automatic model_advance(input bit cg, input bit eg);
    if (rst) begin
      m_locked = 1'b0; m_wait = 0; m_core_rv = 1'b0; m_ext_rv = 1'b0;
      return;
    end
    m_core_rv = cg && !core_we;
    m_ext_rv  = eg && !ext_we;
    if (cg) begin
      if (core_we) ref_mem[core_addr] = core_wdata;
      else m_core_rd = ref_mem[core_addr];
    end
    if (eg) begin
      if (ext_we) ref_mem[ext_addr] = ext_wdata;
      else m_ext_rd = ref_mem[ext_addr];
      m_locked = ext_lock;
    end
    if (eg || !ext_req) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
  endtask

  task automatic test_random();
    bit cg, eg, prev_cg, prev_eg;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic [4:0] exp_ctl;
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = ADDR_W'(a); ext_wdata = DATA_W'($urandom);
      ref_mem[a] = ext_wdata;
      #1;
      checks++;
      if (ext_gnt !== 1'b1) begin
        failures++;
        $display("[TB] FAIL random_init %0d: got ext_gnt=%b expected 1", a, ext_gnt);
      end
      @(negedge clk);
    end
    idle();
    m_locked = 1'b0; m_wait = 0; m_core_rv = 1'b0; m_ext_rv = 1'b0;
    prev_cg = 1'b1; prev_eg = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!core_req || prev_cg) begin
        core_req = ($urandom_range(0, 2) != 0); core_we = $urandom_range(0, 1);
        core_addr = ADDR_W'($urandom); core_wdata = DATA_W'($urandom);
      end
      if (!ext_req || prev_eg) begin
        ext_req = ($urandom_range(0, 2) != 0); ext_we = $urandom_range(0, 1);
        ext_lock = ($urandom_range(0, 2) == 0);
        ext_addr = ADDR_W'($urandom); ext_wdata = DATA_W'($urandom);
      end
      halt = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 39) == 0);
      #1;
      model_grant(cg, eg);
      exp_addr  = eg ? ext_addr : (cg ? core_addr : '0);
      exp_wdata = eg ? ext_wdata : (cg ? core_wdata : '0);
      exp_ctl   = {cg, eg, (eg && ext_we) || (cg && core_we), eg, cg};
      checks++;
      if ({core_gnt, ext_gnt, ram_we, owner} !== exp_ctl) begin
        failures++;
        $display("[TB] FAIL random_grant %0d: got {cg,eg,we,owner}=%b expected %b",
                 n, {core_gnt, ext_gnt, ram_we, owner}, exp_ctl);
      end
      checks++;
      if (ram_addr !== exp_addr || ram_wdata !== exp_wdata) begin
        failures++;
        $display("[TB] FAIL random_ram_bus %0d: got addr=%0d data=%h expected addr=%0d data=%h",
                 n, ram_addr, ram_wdata, exp_addr, exp_wdata);
      end
      checks++;
      if (core_rvalid !== (m_core_rv && !rst) || ext_rvalid !== (m_ext_rv && !rst)) begin
        failures++;
        $display("[TB] FAIL random_rvalid %0d: got core=%b ext=%b expected core=%b ext=%b",
                 n, core_rvalid, ext_rvalid, m_core_rv && !rst, m_ext_rv && !rst);
      end
      if (m_core_rv && !rst) begin
        checks++;
        if (core_rdata !== m_core_rd) begin
          failures++;
          $display("[TB] FAIL random_core_rdata %0d: got %h expected %h", n, core_rdata, m_core_rd);
        end
      end
      if (m_ext_rv && !rst) begin
        checks++;
        if (ext_rdata !== m_ext_rd) begin
          failures++;
          $display("[TB] FAIL random_ext_rdata %0d: got %h expected %h", n, ext_rdata, m_ext_rd);
        end
      end
      model_advance(cg, eg);
      prev_cg = cg;
      prev_eg = eg;
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_core_read();
    test_starvation();
    test_halt();
    test_locked_burst();
    test_reset_mid_lock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
